// File: rtl/marie_pkg.sv
// Shared types and constants for the MARIE accumulator CPU control unit.
package marie_pkg;

    localparam int MARIE_ADDR_W = 12;
    localparam int MARIE_DATA_W = 16;
    localparam int MARIE_OP_W   = 4;

    // Supported instruction opcodes (IR[15:12]); anything else decodes as illegal.
    typedef enum logic [3:0] {
        OP_LOAD     = 4'h1,
        OP_STORE    = 4'h2,
        OP_ADD      = 4'h3,
        OP_SUBT     = 4'h4,
        OP_HALT     = 4'h7,
        OP_SKIPCOND = 4'h8,
        OP_JUMP     = 4'h9,
        OP_CLEAR    = 4'hA,
        OP_ADDI     = 4'hB,
        OP_JUMPI    = 4'hC
    } opcode_t;

    // Sequencer states.
    typedef enum logic [3:0] {
        S_IDLE,
        S_F0,
        S_F1,
        S_F2,
        S_DECODE,
        S_RD1,
        S_RD2,
        S_IND,
        S_EXEC,
        S_WRITE,
        S_HALTED
    } state_t;

    // Skipcond condition field IR[11:10]; 2'b11 never skips.
    localparam logic [1:0] SKIP_LT = 2'b00;
    localparam logic [1:0] SKIP_EQ = 2'b01;
    localparam logic [1:0] SKIP_GT = 2'b10;

    // ALU operation codes.
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;

endpackage

// File: rtl/marie_control_unit_if.sv
// Main-memory port: the control unit is the master, the memory the slave.
interface marie_control_unit_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_we,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_we,
        output mem_rdata
    );
endinterface

// File: rtl/marie_control_unit_alu.sv
// Accumulator ALU: modulo-2^DATA_W add/subtract, no flags.
module marie_control_unit_alu
    import marie_pkg::*;
#(
    parameter int DATA_W = MARIE_DATA_W
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);

    // Select the operation; unknown codes fall back to add.
    always_comb begin
        y = a + b;
        case (op)
            ALU_SUB: y = a - b;
            default: y = a + b;
        endcase
    end

endmodule

// File: rtl/marie_control_unit.sv
// Fetch/decode/execute sequencer for the MARIE 16-bit accumulator CPU.
// Owns AC/PC/MAR/MBR/IR and masters a 1-cycle-latency synchronous memory.
module marie_control_unit
    import marie_pkg::*;
#(
    parameter int                ADDR_W   = MARIE_ADDR_W,
    parameter int                DATA_W   = MARIE_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    marie_control_unit_if.master      mem,
    output logic                      busy,
    output logic                      halted,
    output logic                      instr_done,
    output logic                      illegal,
    output logic [DATA_W-1:0]         ac,
    output logic [ADDR_W-1:0]         pc,
    output logic [DATA_W-1:0]         ir
);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   ac_q, ac_d;
    logic [DATA_W-1:0]   mbr_q, mbr_d;
    logic [DATA_W-1:0]   ir_q, ir_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   mar_q, mar_d;
    logic                ind_q, ind_d;

    opcode_t             op;
    logic [3:0]          alu_op;
    logic [DATA_W-1:0]   alu_y;
    logic                ac_neg, ac_zero, skip;
    logic                decode_done, decode_illegal;

    assign op      = opcode_t'(ir_q[DATA_W-1 -: MARIE_OP_W]);
    assign alu_op  = (op == OP_SUBT) ? ALU_SUB : ALU_ADD;
    assign ac_neg  = ac_q[DATA_W-1];
    assign ac_zero = (ac_q == '0);

    marie_control_unit_alu #(.DATA_W(DATA_W)) u_alu (
        .op (alu_op),
        .a  (ac_q),
        .b  (mbr_q),
        .y  (alu_y)
    );

    // Skipcond condition evaluation on the signed accumulator.
    always_comb begin
        skip = 1'b0;
        case (ir_q[ADDR_W-1 -: 2])
            SKIP_LT: skip = ac_neg;
            SKIP_EQ: skip = ac_zero;
            SKIP_GT: skip = !ac_neg && !ac_zero;
            default: skip = 1'b0;
        endcase
    end

    // Next-state and register-transfer logic for every sequencer state.
    always_comb begin
        state_d        = state_q;
        ac_d           = ac_q;
        mbr_d          = mbr_q;
        ir_d           = ir_q;
        pc_d           = pc_q;
        mar_d          = mar_q;
        ind_d          = ind_q;
        decode_done    = 1'b0;
        decode_illegal = 1'b0;
        case (state_q)
            S_IDLE: if (start) state_d = S_F0;
            S_F0: begin
                mar_d   = pc_q;
                state_d = S_F1;
            end
            S_F1: state_d = S_F2;
            S_F2: begin
                ir_d    = mem.mem_rdata;
                pc_d    = pc_q + 1'b1;
                mar_d   = mem.mem_rdata[ADDR_W-1:0];
                state_d = S_DECODE;
            end
            S_DECODE: begin
                decode_done = 1'b1;
                state_d     = S_F0;
                case (op)
                    OP_LOAD, OP_ADD, OP_SUBT, OP_ADDI, OP_JUMPI: begin
                        decode_done = 1'b0;
                        state_d     = S_RD1;
                    end
                    OP_STORE: begin
                        decode_done = 1'b0;
                        state_d     = S_WRITE;
                    end
                    OP_JUMP:     pc_d = ir_q[ADDR_W-1:0];
                    OP_CLEAR:    ac_d = '0;
                    OP_SKIPCOND: if (skip) pc_d = pc_q + 1'b1;
                    OP_HALT:     state_d = S_HALTED;
                    default:     decode_illegal = 1'b1;
                endcase
            end
            S_RD1: state_d = S_RD2;
            S_RD2: begin
                mbr_d   = mem.mem_rdata;
                // AddI takes a second read through the pointer just fetched.
                state_d = (op == OP_ADDI && !ind_q) ? S_IND : S_EXEC;
            end
            S_IND: begin
                mar_d   = mbr_q[ADDR_W-1:0];
                ind_d   = 1'b1;
                state_d = S_RD1;
            end
            S_EXEC: begin
                case (op)
                    OP_LOAD:                   ac_d = mbr_q;
                    OP_ADD, OP_ADDI, OP_SUBT:  ac_d = alu_y;
                    OP_JUMPI:                  pc_d = mbr_q[ADDR_W-1:0];
                    default:                   ac_d = ac_q;
                endcase
                ind_d   = 1'b0;
                state_d = S_F0;
            end
            S_WRITE:  state_d = S_F0;
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_IDLE;
        endcase
    end

    // Architectural and sequencer registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ac_q    <= '0;
            mbr_q   <= '0;
            ir_q    <= '0;
            pc_q    <= RESET_PC;
            mar_q   <= '0;
            ind_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ac_q    <= ac_d;
            mbr_q   <= mbr_d;
            ir_q    <= ir_d;
            pc_q    <= pc_d;
            mar_q   <= mar_d;
            ind_q   <= ind_d;
        end
    end

    // Write enable decodes straight from state so reset kills it at once.
    assign mem.mem_we    = (state_q == S_WRITE);
    assign mem.mem_addr  = {{(DATA_W-ADDR_W){1'b0}}, mar_q};
    assign mem.mem_wdata = ac_q;

    assign busy       = (state_q != S_IDLE) && (state_q != S_HALTED);
    assign halted     = (state_q == S_HALTED);
    assign instr_done = decode_done || (state_q == S_WRITE) || (state_q == S_EXEC);
    assign illegal    = decode_illegal;
    assign ac         = ac_q;
    assign pc         = pc_q;
    assign ir         = ir_q;

endmodule
